// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - fetch/data request-response channels and shared memory port
interface mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ireq_val;
    logic          ireq_rdy;
    logic [AW-1:0] ireq_addr;
    logic          iresp_val;
    logic          iresp_rdy;
    logic [DW-1:0] iresp_data;

    logic          dreq_val;
    logic          dreq_rdy;
    logic          dreq_type;
    logic [AW-1:0] dreq_addr;
    logic [DW-1:0] dreq_wdata;
    logic          dresp_val;
    logic          dresp_rdy;
    logic [DW-1:0] dresp_data;

    logic          memreq_val;
    logic          memreq_type;
    logic [AW-1:0] memreq_addr;
    logic [DW-1:0] memreq_wdata;
    logic [DW-1:0] memresp_data;

    modport slave (
        input  ireq_val, ireq_addr, iresp_rdy,
        input  dreq_val, dreq_type, dreq_addr, dreq_wdata, dresp_rdy,
        input  memresp_data,
        output ireq_rdy, iresp_val, iresp_data,
        output dreq_rdy, dresp_val, dresp_data,
        output memreq_val, memreq_type, memreq_addr, memreq_wdata
    );

    modport master (
        output ireq_val, ireq_addr, iresp_rdy,
        output dreq_val, dreq_type, dreq_addr, dreq_wdata, dresp_rdy,
        output memresp_data,
        input  ireq_rdy, iresp_val, iresp_data,
        input  dreq_rdy, dresp_val, dresp_data,
        input  memreq_val, memreq_type, memreq_addr, memreq_wdata
    );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - round-robin arbiter of fetch and data requesters onto one single-port memory
module mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic       OWN_I  = 1'b0;
    localparam logic       OWN_D  = 1'b1;

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_owner;
    logic          r_wr;
    logic [DW-1:0] r_buf;

    logic          w_idle;
    logic          w_busy;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_own_rdy;
    logic [DW-1:0] w_resp_data;
    logic [AW-1:0] w_mem_addr;

    // Grants are also suppressed while rst is high so no handshake can complete under reset.
    assign w_idle    = (r_state == S_IDLE) && !rst;
    assign w_busy    = (r_state == S_WAIT) || (r_state == S_HOLD);
    assign w_grant_i = w_idle && bus.ireq_val && (!bus.dreq_val || (r_last == OWN_D));
    assign w_grant_d = w_idle && bus.dreq_val && !w_grant_i;

    assign w_mem_addr = w_grant_i ? bus.ireq_addr :
                        w_grant_d ? bus.dreq_addr : '0;

    assign bus.ireq_rdy     = w_grant_i;
    assign bus.dreq_rdy     = w_grant_d;
    assign bus.memreq_val   = w_grant_i || w_grant_d;
    assign bus.memreq_type  = w_grant_d && bus.dreq_type;
    assign bus.memreq_addr  = w_mem_addr;
    assign bus.memreq_wdata = w_grant_d ? bus.dreq_wdata : '0;

    // Memory data is only live in WAIT; HOLD replays the captured copy.
    assign w_resp_data = (r_state == S_HOLD) ? r_buf :
                         r_wr                ? '0    : bus.memresp_data;
    assign w_own_rdy   = (r_owner == OWN_D) ? bus.dresp_rdy : bus.iresp_rdy;

    assign bus.iresp_val  = w_busy && (r_owner == OWN_I);
    assign bus.dresp_val  = w_busy && (r_owner == OWN_D);
    assign bus.iresp_data = bus.iresp_val ? w_resp_data : '0;
    assign bus.dresp_data = bus.dresp_val ? w_resp_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= OWN_D;
            r_owner <= OWN_I;
            r_wr    <= 1'b0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_i || w_grant_d) begin
                        r_state <= S_WAIT;
                        r_owner <= w_grant_d;
                        r_last  <= w_grant_d;
                        r_wr    <= w_grant_d && bus.dreq_type;
                    end
                end
                S_WAIT: begin
                    if (w_own_rdy) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_buf   <= w_resp_data;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_own_rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - randomized and directed self-checking bench for mem_arb
module tb_mem_arb;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    bit          m_pend;
    bit          m_to;
    bit          m_last;
    logic [31:0] m_data;

    mem_arb_if #(.AW(AW), .DW(DW)) dif ();

    mem_arb #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 2)  return 32'h00A00093;
        if (i == 13) return 32'h0000_1234;
        return 32'hC0DE_0000 | (32'(i) * 32'h0000_0111);
    endfunction

    // Memory with one-cycle read latency; non-read cycles put noise on the read bus.
    always @(posedge clk) begin
        if (dif.memreq_val && dif.memreq_type)
            mem[dif.memreq_addr[7:2]] <= dif.memreq_wdata;
        if (dif.memreq_val && !dif.memreq_type)
            dif.memresp_data <= mem[dif.memreq_addr[7:2]];
        else
            dif.memresp_data <= $urandom;
    end

    // Reference: at most one outstanding response; grants follow round-robin when none is pending.
    always @(negedge clk) begin : cmp
        logic        ei;
        logic        ed;
        logic [31:0] a;
        if (rst) begin
            chk("rst_ireq_rdy", dif.ireq_rdy, 0);
            chk("rst_dreq_rdy", dif.dreq_rdy, 0);
            chk("rst_iresp_val", dif.iresp_val, 0);
            chk("rst_dresp_val", dif.dresp_val, 0);
            chk("rst_memreq_val", dif.memreq_val, 0);
            chk("rst_iresp_data", dif.iresp_data, 0);
            chk("rst_dresp_data", dif.dresp_data, 0);
            m_pend = 0;
            m_last = 1;
        end else if (!m_pend) begin
            ei = dif.ireq_val && (!dif.dreq_val || m_last);
            ed = dif.dreq_val && !ei;
            a  = ei ? dif.ireq_addr : ed ? dif.dreq_addr : 32'h0;
            chk("ireq_rdy", dif.ireq_rdy, ei);
            chk("dreq_rdy", dif.dreq_rdy, ed);
            chk("memreq_val", dif.memreq_val, ei || ed);
            chk("memreq_type", dif.memreq_type, ed && dif.dreq_type);
            chk("memreq_addr", dif.memreq_addr, a);
            chk("memreq_wdata", dif.memreq_wdata, ed ? dif.dreq_wdata : 32'h0);
            chk("iresp_val_idle", dif.iresp_val, 0);
            chk("dresp_val_idle", dif.dresp_val, 0);
            if (ei || ed) begin
                m_pend = 1;
                m_to   = ed;
                m_last = ed;
                if (ed && dif.dreq_type) begin
                    m_data = 32'h0;
                    ref_mem[a[7:2]] = dif.dreq_wdata;
                end else begin
                    m_data = ref_mem[a[7:2]];
                end
            end
        end else begin
            chk("ireq_rdy_busy", dif.ireq_rdy, 0);
            chk("dreq_rdy_busy", dif.dreq_rdy, 0);
            chk("memreq_val_busy", dif.memreq_val, 0);
            chk("memreq_addr_busy", dif.memreq_addr, 0);
            chk("iresp_val", dif.iresp_val, !m_to);
            chk("dresp_val", dif.dresp_val, m_to);
            chk("iresp_data", dif.iresp_data, m_to ? 32'h0 : m_data);
            chk("dresp_data", dif.dresp_data, m_to ? m_data : 32'h0);
            if (m_to ? dif.dresp_rdy : dif.iresp_rdy)
                m_pend = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic new_i();
        logic [31:0] a;
        a = $urandom;
        dif.ireq_val  = ($urandom_range(0, 99) < 65);
        dif.ireq_addr = a & 32'hF000_00FF;
    endtask

    task automatic new_d();
        logic [31:0] a;
        a = $urandom;
        dif.dreq_val   = ($urandom_range(0, 99) < 65);
        dif.dreq_type  = $urandom_range(0, 1);
        dif.dreq_addr  = a & 32'hF000_00FF;
        dif.dreq_wdata = $urandom;
    endtask

    initial begin
        logic ti;
        logic td;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        dif.ireq_val = 0; dif.ireq_addr = 0; dif.iresp_rdy = 1;
        dif.dreq_val = 0; dif.dreq_type = 0; dif.dreq_addr = 0;
        dif.dreq_wdata = 0; dif.dresp_rdy = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Single fetch of word 2
        dif.ireq_val = 1; dif.ireq_addr = 32'h8;
        mid(); chk("lit_fetch_grant", dif.ireq_rdy, 1);
        tick(); dif.ireq_val = 0;
        mid(); chk("lit_fetch_val", dif.iresp_val, 1);
        chk("lit_fetch_data", dif.iresp_data, 32'h00A00093);
        tick();

        // Tie from reset: I, D, I, D on cycles 0, 2, 4, 6
        rst = 1;
        dif.ireq_val = 1; dif.ireq_addr = 32'h10;
        dif.dreq_val = 1; dif.dreq_type = 0; dif.dreq_addr = 32'h20;
        mid(); chk("lit_rst_irdy", dif.ireq_rdy, 0);
        chk("lit_rst_drdy", dif.dreq_rdy, 0);
        tick(); rst = 0;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("lit_tie_i", dif.ireq_rdy, (k % 4) == 0);
            chk("lit_tie_d", dif.dreq_rdy, (k % 4) == 2);
            tick();
        end
        dif.ireq_val = 0; dif.dreq_val = 0;

        // Write then read back at 0x40
        dif.dreq_val = 1; dif.dreq_type = 1; dif.dreq_addr = 32'h40; dif.dreq_wdata = 32'hDEADBEEF;
        mid(); chk("lit_wr_grant", dif.dreq_rdy, 1);
        chk("lit_wr_type", dif.memreq_type, 1);
        tick(); dif.dreq_type = 0;
        mid(); chk("lit_wr_ack_val", dif.dresp_val, 1);
        chk("lit_wr_ack_data", dif.dresp_data, 32'h0);
        tick();
        mid(); chk("lit_rd_grant", dif.dreq_rdy, 1);
        tick(); dif.dreq_val = 0;
        mid(); chk("lit_rd_data", dif.dresp_data, 32'hDEADBEEF);
        tick();

        // Fetch response backpressure with a competing data request
        dif.ireq_val = 1; dif.ireq_addr = 32'h1234; dif.iresp_rdy = 0;
        dif.dreq_val = 1; dif.dreq_type = 0; dif.dreq_addr = 32'h0;
        mid(); chk("lit_bp_grant", dif.ireq_rdy, 1);
        tick(); dif.ireq_val = 0;
        repeat (3) begin
            mid();
            chk("lit_bp_val", dif.iresp_val, 1);
            chk("lit_bp_data", dif.iresp_data, 32'h1234);
            chk("lit_bp_nogrant", dif.dreq_rdy, 0);
            tick();
        end
        dif.iresp_rdy = 1;
        mid(); chk("lit_bp_last", dif.iresp_data, 32'h1234);
        chk("lit_bp_last_nogrant", dif.dreq_rdy, 0);
        tick();
        mid(); chk("lit_bp_release", dif.dreq_rdy, 1);
        tick(); dif.dreq_val = 0;
        mid(); tick();

        // Reset while a data read is in flight
        dif.dreq_val = 1; dif.dreq_type = 0; dif.dreq_addr = 32'h8; dif.dresp_rdy = 0;
        mid(); chk("lit_rw_grant", dif.dreq_rdy, 1);
        tick(); dif.dreq_val = 0;
        mid(); chk("lit_rw_wait", dif.dresp_val, 1);
        #2 rst = 1;
        #1 chk("lit_rw_async", dif.dresp_val, 0);
        tick(); mid();
        tick(); rst = 0;
        dif.ireq_val = 1; dif.dreq_val = 1; dif.dresp_rdy = 1;
        mid(); chk("lit_rw_tie_i", dif.ireq_rdy, 1);
        chk("lit_rw_no_dresp", dif.dresp_val, 0);
        tick(); dif.ireq_val = 0;
        mid(); chk("lit_rw_no_dresp2", dif.dresp_val, 0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ti = dif.ireq_val && dif.ireq_rdy;
            td = dif.dreq_val && dif.dreq_rdy;
            @(posedge clk);
            #1;
            if (!dif.ireq_val || ti) new_i();
            if (!dif.dreq_val || td) new_d();
            dif.iresp_rdy = ($urandom_range(0, 3) != 0);
            dif.dresp_rdy = ($urandom_range(0, 3) != 0);
        end

        dif.ireq_val = 0; dif.dreq_val = 0;
        dif.iresp_rdy = 1; dif.dresp_rdy = 1;
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
